// File: rtl/bcd_time_counter.sv
// 24-hour BCD time-of-day counter with a 1 Hz prescaler, button adjust of hours
// and minutes, and a seconds clear. Feeds the 24h-to-12h hour converter.
module bcd_time_counter #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned PW      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       adj_hour,
  input  logic       adj_min,
  input  logic       clr_sec,
  output logic [3:0] bcd_ht,
  output logic [3:0] bcd_hu,
  output logic [3:0] bcd_mt,
  output logic [3:0] bcd_mu,
  output logic [3:0] bcd_st,
  output logic [3:0] bcd_su,
  output logic       tick_1hz,
  output logic       hour_pulse
);

  localparam logic [PW-1:0] TC = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc, presc_nx;
  logic [3:0]    ht_nx, hu_nx, mt_nx, mu_nx, st_nx, su_nx;
  logic          at_tc, tick_c, adv_c, sec_wrap, min_wrap, min_inc, hour_inc, hour_carry;

  // Tick qualification and carry chain; an adjust at terminal count defers the tick.
  always_comb begin
    at_tc      = (presc == TC);
    tick_c     = run & at_tc & ~adj_hour & ~adj_min;
    adv_c      = tick_c & ~clr_sec;
    sec_wrap   = (bcd_st == 4'd5) && (bcd_su == 4'd9);
    min_wrap   = (bcd_mt == 4'd5) && (bcd_mu == 4'd9);
    hour_carry = adv_c & sec_wrap & min_wrap;
    min_inc    = adj_min | (adv_c & sec_wrap);
    hour_inc   = adj_hour | hour_carry;

    presc_nx = presc;
    if (clr_sec) begin
      presc_nx = '0;
    end else if (run) begin
      if (!at_tc)      presc_nx = presc + PW'(1);
      else if (tick_c) presc_nx = '0;
    end
  end

  // Next-state digits for seconds, minutes and hours.
  always_comb begin
    su_nx = bcd_su;
    st_nx = bcd_st;
    mu_nx = bcd_mu;
    mt_nx = bcd_mt;
    hu_nx = bcd_hu;
    ht_nx = bcd_ht;

    if (clr_sec) begin
      su_nx = 4'd0;
      st_nx = 4'd0;
    end else if (adv_c) begin
      if (bcd_su == 4'd9) begin
        su_nx = 4'd0;
        st_nx = (bcd_st == 4'd5) ? 4'd0 : bcd_st + 4'd1;
      end else begin
        su_nx = bcd_su + 4'd1;
      end
    end

    if (min_inc) begin
      if (bcd_mu == 4'd9) begin
        mu_nx = 4'd0;
        mt_nx = (bcd_mt == 4'd5) ? 4'd0 : bcd_mt + 4'd1;
      end else begin
        mu_nx = bcd_mu + 4'd1;
      end
    end

    if (hour_inc) begin
      if (bcd_ht == 4'd2 && bcd_hu == 4'd3) begin
        ht_nx = 4'd0;
        hu_nx = 4'd0;
      end else if (bcd_hu == 4'd9) begin
        hu_nx = 4'd0;
        ht_nx = bcd_ht + 4'd1;
      end else begin
        hu_nx = bcd_hu + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      bcd_ht     <= 4'd0;
      bcd_hu     <= 4'd0;
      bcd_mt     <= 4'd0;
      bcd_mu     <= 4'd0;
      bcd_st     <= 4'd0;
      bcd_su     <= 4'd0;
      tick_1hz   <= 1'b0;
      hour_pulse <= 1'b0;
    end else begin
      presc      <= presc_nx;
      bcd_ht     <= ht_nx;
      bcd_hu     <= hu_nx;
      bcd_mt     <= mt_nx;
      bcd_mu     <= mu_nx;
      bcd_st     <= st_nx;
      bcd_su     <= su_nx;
      tick_1hz   <= adv_c;
      hour_pulse <= hour_carry;
    end
  end

endmodule
